// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
// Arbitrates exception, multi-cycle EX and load-use requests into a
// per-stage freeze vector, issues a one-cycle flush with redirect PC,
// and keeps a saturating count of PC-stall cycles.
module pipe_ctrl #(
  parameter int MC_W = 6,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            ex_mc_start,
  input  logic [MC_W-1:0] ex_mc_cycles,
  input  logic            ex_mc_done,
  input  logic            excp_req,
  input  logic [PC_W-1:0] excp_pc,
  output logic [5:0]      stall,
  output logic            flush,
  output logic [PC_W-1:0] new_pc,
  output logic            mc_busy,
  output logic [31:0]     stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Freeze patterns: load-use holds PC..ID/EX, multi-cycle also holds
  // EX/MEM, and an exception additionally holds MEM/WB until the flush.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_EXC  = 6'b011111;

  state_t          state, state_nxt;
  logic [MC_W-1:0] cnt, cnt_nxt;
  logic            load_pc;

  // Next-state, down-counter and stall vector; exception beats multi-cycle beats load-use.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = STALL_NONE;
    load_pc   = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (excp_req) begin
            stall     = STALL_EXC;
            load_pc   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = FLUSH;
          end else if (ex_mc_start && (ex_mc_cycles >= MC_W'(2))) begin
            stall     = STALL_MC;
            cnt_nxt   = ex_mc_cycles - MC_W'(1);
            state_nxt = MC_WAIT;
          end else if (ex_mc_start && (ex_mc_cycles == MC_W'(1))) begin
            stall = STALL_MC;
          end else if (stallreq_id) begin
            stall = STALL_LU;
          end
        end
        MC_WAIT: begin
          stall = STALL_MC;
          if (excp_req) begin
            stall     = STALL_EXC;
            load_pc   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = FLUSH;
          end else if ((cnt == MC_W'(1)) || ex_mc_done) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - MC_W'(1);
          end
        end
        FLUSH: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and multi-cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered flush/redirect and busy flag, derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush   <= 1'b0;
      new_pc  <= '0;
      mc_busy <= 1'b0;
    end else begin
      flush   <= (state_nxt == FLUSH);
      mc_busy <= (state_nxt == MC_WAIT);
      if (load_pc) begin
        new_pc <= excp_pc;
      end
    end
  end

  // Saturating count of cycles in which the PC was frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It takes hazard and multi-cycle requests from ID and EX, plus exception requests from MEM. From these it drives the per-stage stall vector that freezes the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and it issues a one-cycle flush with a redirect PC. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- MC_W, 6, width of the multi-cycle length field.
- PC_W, 32, width of the redirect PC.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq_id  in  1  load-use hazard from ID; level, valid for the current cycle.
- ex_mc_start  in  1  EX begins a multi-cycle op (div, madd/msub); one-cycle pulse.
- ex_mc_cycles  in  MC_WIDTH  total stall cycles N for that op; sampled with ex_mc_start.
- ex_mc_done  in  1  early-completion strobe from the EX multi-cycle unit.
- excp_req  in  1  exception/flush request from MEM; one-cycle pulse.
- excp_pc  in  PC_W  handler address; sampled with excp_req.
- stall  out  6  freeze enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (always 0).
- flush  out  1  clear all pipeline registers and redirect fetch.
- new_pc  out  PC_W  redirect target; valid when flush=1.
- mc_busy  out  1  high while in MC_WAIT.
- stall_cnt  out  32  saturating count of cycles with stall[0]=1.

## Operation
- States:
  - RUN: normal operation.
  - MC_WAIT: holding for a multi-cycle EX op; 6-bit down-counter `cnt`.
  - FLUSH: one-cycle redirect after an exception.
- stall is combinational from state and inputs. flush, new_pc, mc_busy and stall_cnt are registered.
- Request priority (highest first): excp_req, then EX multi-cycle, then stallreq_id.
- RUN:
  - excp_req: stall=6'b011111; latch excp_pc; next state FLUSH.
  - Otherwise, ex_mc_start with N≥2: stall=6'b001111; cnt←N−1; next state MC_WAIT.
  - Otherwise, ex_mc_start with N=1: stall=6'b001111 this cycle only; stay in RUN.
  - ex_mc_start with N=0: ignored; it gives no stall.
  - Otherwise, stallreq_id: stall=6'b000111; stay in RUN.
  - Otherwise: stall=0.
- MC_WAIT:
  - stall=6'b001111; cnt decrements each cycle.
  - Next state RUN when cnt==1 or ex_mc_done. That cycle is the last stalled cycle.
  - ex_mc_start and stallreq_id are ignored; ID is frozen and EX is owned.
  - excp_req: abort the op; stall=6'b011111; cnt←0; next state FLUSH.
- FLUSH:
  - flush=1, new_pc=latched excp_pc, stall=0; next state RUN.
  - All requests are ignored, including a new excp_req.
- flush is high only in the FLUSH cycle. new_pc holds its last value otherwise.
- stall_cnt increments on every cycle where stall[0]=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset:
  - While rst=1, stall=0 combinationally.
  - After the reset edge: state=RUN, cnt=0, flush=0, new_pc=0, mc_busy=0, stall_cnt=0.
  - A reset mid-MC_WAIT or mid-FLUSH abandons the operation with no flush issued.
- Load-use: stall[2:0] is asserted in the same cycle as stallreq_id, with zero latency.
- Multi-cycle op started at cycle T with N≥2 and no early done:
  - stall[3:0] asserted for cycles T through T+N−1.
  - mc_busy high for T+1 through T+N−1.
  - Pipeline advances at T+N.
- ex_mc_done at cycle T+k (1≤k≤N−1): T+k is the last stalled cycle; RUN at T+k+1.
- Exception at cycle T: freeze at T; flush=1 and new_pc valid at T+1; RUN at T+2. Total latency is 1 cycle.
- Simultaneous requests:
  - excp_req with ex_mc_start: the mc start is dropped.
  - ex_mc_start with stallreq_id: stall=6'b001111 (superset).

## Test plan
- Reset:
  - Assert rst for 2 cycles while excp_req=1 and ex_mc_start=1.
  - Required: stall=0, flush=0, new_pc=0, stall_cnt=0; state is RUN after release.
- Load-use:
  - stallreq_id=1 for 2 cycles.
  - Required: stall=6'b000111 in both cycles, then 0; stall_cnt=2.
- Multi-cycle op:
  - ex_mc_start with N=5 at T.
  - Required: stall=6'b001111 for T..T+4; mc_busy for T+1..T+4; stall=0 at T+5; stall_cnt=5.
  - Repeat with N=1: one stall cycle and no mc_busy. Repeat with N=0: no stall.
- Early done:
  - N=34, ex_mc_done at T+3.
  - Required: last stall at T+3; RUN with stall=0 at T+4.
- Exception abort:
  - During MC_WAIT (N=10), excp_req at T+2 with excp_pc=32'h0000_0040.
  - Required: stall=6'b011111 at T+2; flush=1 with new_pc=32'h40 at T+3; stall=0 and mc_busy=0 at T+4.
  - A second excp_req at T+3 is ignored.
- Priority and saturation:
  - stallreq_id, ex_mc_start (N=3) and excp_req in the same cycle → exception path only.
  - Force stall_cnt to 32'hFFFF_FFFE, then stall 3 cycles → stall_cnt holds at 32'hFFFF_FFFF.
